hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised register scoreboard for the pipelined MIPS core. It replaces fixed single-cycle RAW/load-use hazard detection with per-register pending-write countdowns, so variable-latency units (multi-cycle FPU, memory) can issue in order. The decode/issue stage uses it to generate the decode stall, per-operand bypass flags and a per-register write-retire mask.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers tracked; register 0 is never tracked.
- `AW`, `$clog2(NREG)`: register address width.
- `LW`, 4: latency field width; maximum latency `MAXLAT` = 2**LW-1.
- `NSRC`, 2: source operands checked per issue.
- `FWD_DIST`, 1: largest pending count at which a source can be bypassed instead of stalled (0..MAXLAT; 0 disables bypass).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: an instruction is presented for issue.
- `issue_wr` in 1: the presented instruction writes a register.
- `issue_dst` in AW: destination register.
- `issue_lat` in LW: cycles until the write completes, 1..MAXLAT.
- `src` in NSRC*AW: packed source addresses, operand i at [i*AW +: AW].
- `src_used` in NSRC: operand i is actually read.
- `flush` in 1: discard all pending writes (branch/jump redirect).
- `stall` out 1: issue is refused this cycle.
- `fwd` out NSRC: operand i must take the bypass path.
- `busy` out NREG: register has a pending write.
- `retire_mask` out NREG: register's write completes this cycle.

## Operation
- State is `cnt[r]` (LW bits) for each r in 1..NREG-1. `cnt[0]` is constant 0.
- Accept = `issue_valid & !stall & !flush`.
- RAW hazard on operand i: `src_used[i]` and `cnt[src_i] > FWD_DIST`.
- WAW hazard: `issue_wr` and `cnt[issue_dst] > issue_lat`. This keeps completions in order. Equal counts are allowed because the old write retires one cycle earlier.
- `stall = issue_valid & (any RAW | WAW)`. This is combinational. `flush` does not suppress `stall`.
- `fwd[i] = src_used[i] & cnt[src_i] != 0 & cnt[src_i] <= FWD_DIST`. An operand addressing r0 never sets `fwd` or stalls.
- `busy[r] = cnt[r] != 0`.
- `retire_mask[r] = cnt[r] == 1`.
- Each edge:
  - If `flush`: all `cnt` are set to 0.
  - Else if accept with `issue_wr` and `issue_dst != 0`: `cnt[issue_dst]` is loaded with `issue_lat`. A lat of 0 is treated as 1. The load overrides the decrement for that register.
  - All other nonzero counts decrement by 1.
- Several registers may retire in the same cycle. `retire_mask` is a vector and is not arbitrated.

## Timing
- Reset: all `cnt` = 0, so `busy` = 0 and `retire_mask` = 0. With no pending writes, `stall` = 0 and `fwd` = 0 regardless of inputs.
- Issue accepted at edge E0 with lat L: `busy` goes high after E0, and `retire_mask` is high in the L-th cycle after E0. `busy` falls at the following edge.
- A dependent source issued in the same cycle as its producer sees count 0, so there is no hazard. The producer's own operands are checked against the state before that edge.
- `flush` in a cycle leaves that cycle's `retire_mask` intact, because those writes are older than the flush. No new entry is created that cycle. The effect is visible from the next cycle.
- Reset asserted mid-operation clears all counts immediately (asynchronous), and all outputs return to reset values.
- All outputs are combinational from `cnt` and the inputs. There are no added pipeline stages.

## Configuration
- `HAZARD_SCOREBOARD_STATS_EN` defined:
  - Adds output `stall_cycles`, 32-bit. It counts cycles with `stall`=1 and saturates at 0xFFFFFFFF.
  - Reset to 0 by `rst`; not affected by `flush`.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

## Test plan
- Reset, then `issue_valid`=1, `src`={r3,r4}, no prior issues -> `stall`=0, `fwd`=00, `busy`=0.
- Issue `issue_dst`=r5, lat=1, then next cycle a source r5 with FWD_DIST=1 -> `stall`=0, `fwd[0]`=1, `retire_mask[5]`=1 in that cycle.
- Issue r8 lat=4, next cycle a source r8 (cnt=4) -> `stall`=1 for 3 cycles. Issue is accepted with `fwd`=1 when cnt=1.
- Issue r2 lat=6, next cycle issue r2 lat=3 (cnt=6>3) -> `stall` (WAW). At cnt=3 it is accepted. Retires: old in that cycle+2, new in that cycle+3, never both together.
- Issue r9 lat=5 and r10 lat=5 on consecutive cycles, `flush` two cycles later -> all `busy`=0 next cycle, no `retire_mask` bits for r9/r10.
- With `HAZARD_SCOREBOARD_STATS_EN`, hold a RAW stall for 7 cycles -> `stall_cycles`=7. Assert `rst` low mid-stall -> `stall_cycles`=0 and all `cnt`=0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register scoreboard with per-register pending-write countdowns: decode stall, operand bypass and retire mask.
// Defining HAZARD_SCOREBOARD_STATS_EN adds a saturating stall-cycle counter output (stall_cycles).
module hazard_scoreboard #(
   parameter int NREG     = 32,
   parameter int AW       = $clog2(NREG),
   parameter int LW       = 4,
   parameter int NSRC     = 2,
   parameter int FWD_DIST = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_valid,
   input  logic                 issue_wr,
   input  logic [AW-1:0]        issue_dst,
   input  logic [LW-1:0]        issue_lat,
   input  logic [NSRC*AW-1:0]   src,
   input  logic [NSRC-1:0]      src_used,
   input  logic                 flush,
   output logic                 stall,
   output logic [NSRC-1:0]      fwd,
   output logic [NREG-1:0]      busy,
   output logic [NREG-1:0]      retire_mask
`ifdef HAZARD_SCOREBOARD_STATS_EN
   ,
   output logic [31:0]          stall_cycles
`endif
);

   localparam logic [LW-1:0] FWD_LIM  = LW'(FWD_DIST);
   localparam logic [LW-1:0] ZERO_CNT = {LW{1'b0}};
   localparam logic [LW-1:0] ONE_CNT  = {{(LW-1){1'b0}}, 1'b1};

   logic [LW-1:0] cnt_r [NREG];
   logic [LW-1:0] src_cnt_s [NSRC];
   logic [LW-1:0] dst_cnt_s;
   logic [LW-1:0] lat_eff_s;
   logic          raw_s;
   logic          waw_s;
   logic          stall_s;
   logic          accept_s;

   // Pending count seen by each source operand
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         src_cnt_s[i] = cnt_r[src[i*AW +: AW]];
      end
   end

   // RAW detection and bypass selection; short-distance producers are bypassed, farther ones stall
   always_comb begin
      raw_s = 1'b0;
      fwd   = {NSRC{1'b0}};
      for (int i = 0; i < NSRC; i++) begin
         if (src_used[i] && (src_cnt_s[i] > FWD_LIM)) begin
            raw_s  = 1'b1;
            fwd[i] = 1'b0;
         end else begin
            fwd[i] = src_used[i] && (src_cnt_s[i] != ZERO_CNT);
         end
      end
   end

   // WAW check keeps completions in order; equal counts are safe since the old write retires first
   always_comb begin
      dst_cnt_s = cnt_r[issue_dst];
      waw_s     = issue_wr && (dst_cnt_s > issue_lat);
      stall_s   = issue_valid && (raw_s || waw_s);
      accept_s  = issue_valid && !stall_s && !flush;
      lat_eff_s = (issue_lat == ZERO_CNT) ? ONE_CNT : issue_lat;
   end

   assign stall = stall_s;

   // Per-register status derived directly from the counts
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         busy[r]        = (cnt_r[r] != ZERO_CNT);
         retire_mask[r] = (cnt_r[r] == ONE_CNT);
      end
   end

   // Countdown update: flush clears all, an accepted write loads its latency, others tick down
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_r[r] <= ZERO_CNT;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (r == 0) begin
               cnt_r[r] <= ZERO_CNT;
            end else if (flush) begin
               cnt_r[r] <= ZERO_CNT;
            end else if (accept_s && issue_wr && (issue_dst == AW'(r))) begin
               cnt_r[r] <= lat_eff_s;
            end else if (cnt_r[r] != ZERO_CNT) begin
               cnt_r[r] <= cnt_r[r] - ONE_CNT;
            end else begin
               cnt_r[r] <= cnt_r[r];
            end
         end
      end
   end

`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles_r;

   // Saturating count of stalled cycles; only reset clears it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_r <= 32'd0;
      end else if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
         stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (default parameters), plus reset and statistics sequences.
module tb_hazard_scoreboard;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic        issue_wr;
   logic [4:0]  issue_dst;
   logic [3:0]  issue_lat;
   logic [9:0]  src;
   logic [1:0]  src_used;
   logic        flush;
   logic        stall;
   logic [1:0]  fwd;
   logic [31:0] busy;
   logic [31:0] retire_mask;
`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles;
`endif

   hazard_scoreboard dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_wr    (issue_wr),
      .issue_dst   (issue_dst),
      .issue_lat   (issue_lat),
      .src         (src),
      .src_used    (src_used),
      .flush       (flush),
      .stall       (stall),
      .fwd         (fwd),
      .busy        (busy),
      .retire_mask (retire_mask)
`ifdef HAZARD_SCOREBOARD_STATS_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   typedef struct {
      logic        valid;
      logic        wr;
      logic [4:0]  dst;
      logic [3:0]  lat;
      logic [4:0]  s0;
      logic [4:0]  s1;
      logic [1:0]  used;
      logic        fl;
      logic        e_stall;
      logic [1:0]  e_fwd;
      logic [31:0] e_busy;
      logic [31:0] e_ret;
   } vec_t;

   vec_t vq[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] bm(input int r);
      bm = 32'd1 << r;
   endfunction

   function automatic vec_t mk(input logic valid, input logic wr, input int dst, input int lat,
                               input int s0, input int s1, input logic [1:0] used, input logic fl,
                               input logic e_stall, input logic [1:0] e_fwd,
                               input logic [31:0] e_busy, input logic [31:0] e_ret);
      vec_t v;
      v.valid = valid; v.wr = wr; v.dst = 5'(dst); v.lat = 4'(lat);
      v.s0 = 5'(s0); v.s1 = 5'(s1); v.used = used; v.fl = fl;
      v.e_stall = e_stall; v.e_fwd = e_fwd; v.e_busy = e_busy; v.e_ret = e_ret;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic valid, input logic wr, input int dst, input int lat,
                        input int s0, input int s1, input logic [1:0] used, input logic fl);
      issue_valid = valid;
      issue_wr    = wr;
      issue_dst   = 5'(dst);
      issue_lat   = 4'(lat);
      src         = {5'(s1), 5'(s0)};
      src_used    = used;
      flush       = fl;
   endtask

   initial begin
      // Each row is one cycle: inputs, then expected stall/fwd/busy/retire before the edge
      vq.push_back(mk(1,0, 0,0,  3, 4,2'b11,0, 0,2'b00, 32'd0, 32'd0));              // 0 reset, no hazards
      vq.push_back(mk(1,1, 5,1,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 1 issue r5 lat1
      vq.push_back(mk(1,0, 0,0,  5, 0,2'b01,0, 0,2'b01, bm(5), bm(5)));              // 2 bypass r5
      vq.push_back(mk(1,1, 8,4,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 3 issue r8 lat4
      vq.push_back(mk(1,0, 0,0,  8, 0,2'b01,0, 1,2'b00, bm(8), 32'd0));              // 4 cnt4 stall
      vq.push_back(mk(1,0, 0,0,  8, 0,2'b01,0, 1,2'b00, bm(8), 32'd0));              // 5 cnt3 stall
      vq.push_back(mk(1,0, 0,0,  8, 0,2'b01,0, 1,2'b00, bm(8), 32'd0));              // 6 cnt2 stall
      vq.push_back(mk(1,0, 0,0,  8, 0,2'b01,0, 0,2'b01, bm(8), bm(8)));              // 7 cnt1 bypass
      vq.push_back(mk(1,1, 2,6,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 8 issue r2 lat6
      vq.push_back(mk(1,1, 2,3,  0, 0,2'b00,0, 1,2'b00, bm(2), 32'd0));              // 9 WAW 6>3
      vq.push_back(mk(1,1, 2,3,  0, 0,2'b00,0, 1,2'b00, bm(2), 32'd0));              // 10 WAW 5>3
      vq.push_back(mk(1,1, 2,3,  0, 0,2'b00,0, 1,2'b00, bm(2), 32'd0));              // 11 WAW 4>3
      vq.push_back(mk(1,1, 2,3,  0, 0,2'b00,0, 0,2'b00, bm(2), 32'd0));              // 12 equal, accept
      vq.push_back(mk(0,0, 0,0,  0, 0,2'b00,0, 0,2'b00, bm(2), 32'd0));              // 13 cnt3
      vq.push_back(mk(0,0, 0,0,  0, 0,2'b00,0, 0,2'b00, bm(2), 32'd0));              // 14 cnt2
      vq.push_back(mk(0,0, 0,0,  0, 0,2'b00,0, 0,2'b00, bm(2), bm(2)));              // 15 cnt1 retire
      vq.push_back(mk(1,1, 9,5,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 16 issue r9
      vq.push_back(mk(1,1,10,5,  0, 0,2'b00,0, 0,2'b00, bm(9), 32'd0));              // 17 issue r10
      vq.push_back(mk(0,0, 0,0,  0, 0,2'b00,0, 0,2'b00, bm(9)|bm(10), 32'd0));       // 18
      vq.push_back(mk(0,0, 0,0,  0, 0,2'b00,1, 0,2'b00, bm(9)|bm(10), 32'd0));       // 19 flush
      vq.push_back(mk(1,0, 0,0,  9,10,2'b11,0, 0,2'b00, 32'd0, 32'd0));              // 20 cleared
      vq.push_back(mk(1,1,12,2,  0, 0,2'b00,1, 0,2'b00, 32'd0, 32'd0));              // 21 issue under flush
      vq.push_back(mk(0,0, 0,0,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 22 no entry made
      vq.push_back(mk(1,1, 0,3,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 23 write r0
      vq.push_back(mk(1,0, 0,0,  0, 0,2'b11,0, 0,2'b00, 32'd0, 32'd0));              // 24 r0 untracked
      vq.push_back(mk(1,1, 7,0,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 25 lat0 -> 1
      vq.push_back(mk(1,0, 0,0,  0, 7,2'b10,0, 0,2'b10, bm(7), bm(7)));              // 26 bypass op1
      vq.push_back(mk(1,1,11,2,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 27 issue r11 lat2
      vq.push_back(mk(1,1,12,1,  0, 0,2'b00,0, 0,2'b00, bm(11), 32'd0));             // 28 issue r12 lat1
      vq.push_back(mk(1,0, 0,0, 11, 0,2'b00,0, 0,2'b00, bm(11)|bm(12), bm(11)|bm(12))); // 29 dual retire
      vq.push_back(mk(1,1,13,5,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 30 issue r13
      vq.push_back(mk(1,0, 0,0, 13, 0,2'b01,1, 1,2'b00, bm(13), 32'd0));             // 31 flush keeps stall
      vq.push_back(mk(1,0, 0,0, 13, 0,2'b01,0, 0,2'b00, 32'd0, 32'd0));              // 32 cleared
      vq.push_back(mk(1,1,14,1,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 33 issue r14 lat1
      vq.push_back(mk(0,0, 0,0,  0, 0,2'b00,1, 0,2'b00, bm(14), bm(14)));            // 34 flush keeps retire
      vq.push_back(mk(0,0, 0,0,  0, 0,2'b00,0, 0,2'b00, 32'd0, 32'd0));              // 35 gone

      rst = 1'b0;
      drive(0,0,0,0,0,0,2'b00,0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      chk("reset_busy", -1, busy, 32'd0);
      chk("reset_retire", -1, retire_mask, 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].valid, vq[i].wr, int'(vq[i].dst), int'(vq[i].lat),
               int'(vq[i].s0), int'(vq[i].s1), vq[i].used, vq[i].fl);
         @(negedge clk);
         chk("stall", i, {31'd0, stall}, {31'd0, vq[i].e_stall});
         chk("fwd", i, {30'd0, fwd}, {30'd0, vq[i].e_fwd});
         chk("busy", i, busy, vq[i].e_busy);
         chk("retire", i, retire_mask, vq[i].e_ret);
         @(posedge clk);
         #1;
      end

      // Clean restart, then a seven-cycle RAW stall on r16 (lat 8)
      rst = 1'b0;
      #2;
      rst = 1'b1;
      drive(1,1,16,8,0,0,2'b00,0);
      @(posedge clk);
      #1;
      drive(1,0,0,0,16,0,2'b01,0);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk("stat_stall", k, {31'd0, stall}, 32'd1);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("stat_release", 0, {31'd0, stall}, 32'd0);
      chk("stat_fwd", 0, {30'd0, fwd}, 32'd1);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      chk("stall_cycles", 0, stall_cycles, 32'd7);
`endif
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a stall
      drive(1,1,17,8,0,0,2'b00,0);
      @(posedge clk);
      #1;
      drive(1,0,0,0,17,0,2'b01,0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      chk("mid_stall", 0, {31'd0, stall}, 32'd1);
      chk("mid_busy", 0, busy, bm(17));
      rst = 1'b0;
      #1;
      chk("arst_busy", 0, busy, 32'd0);
      chk("arst_retire", 0, retire_mask, 32'd0);
      chk("arst_stall", 0, {31'd0, stall}, 32'd0);
      chk("arst_fwd", 0, {30'd0, fwd}, 32'd0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      chk("arst_stall_cycles", 0, stall_cycles, 32'd0);
`endif
      #3;
      rst = 1'b1;
      drive(0,0,0,0,0,0,2'b00,0);
      @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
